jtframe_rom_arb: RTL and testbench
==================================

JTFRAME_ROM_ARB -- requirements
Module: jtframe_rom_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, cycles allowed per SDRAM transaction before abort (range 16-4095).
REQ-002 SHALL have port clk_rom  in  1  ROM/SDRAM clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port downloading  in  1  ROM load in progress; blocks and aborts SDRAM traffic.
REQ-005 SHALL have port loop_rst  in  1  SDRAM controller init; flushes caches, blocks traffic.
REQ-006 SHALL have port slot_cs  in  4  per-slot read request, level.
REQ-007 SHALL have port slot_addr  in  88  slot i address at [22i+21:22i].
REQ-008 SHALL have port slot_dout  out  128  slot i cached data at [32i+31:32i].
REQ-009 SHALL have port slot_ok  out  4  slot i data valid for current slot address.
REQ-010 SHALL have port sdram_req  out  1  request to SDRAM controller.
REQ-011 SHALL have port sdram_ack  in  1  controller accepted request, 1-cycle pulse.
REQ-012 SHALL have port sdram_addr  out  22  request address.
REQ-013 SHALL have port data_read  in  32  SDRAM read data.
REQ-014 SHALL have port data_rdy  in  1  data_read valid, 1-cycle pulse.
REQ-015 SHALL have port timeout  out  1  sticky flag, a transaction was aborted by TIMEOUT.

Function
REQ-016 SHALL keep per slot: valid bit, 22-bit tag, 32-bit data register driving slot_dout.
REQ-017 SHALL compute slot_ok[i] combinationally = slot_cs[i] & valid[i] & (tag[i]==current slot_addr[i]); hit served with zero SDRAM access.
REQ-018 SHALL mark slot i pending when slot_cs[i] & ~slot_ok[i].
REQ-019 SHALL implement FSM states IDLE, REQ, WAIT.
REQ-020 IDLE: if ~downloading & ~loop_rst & any pending, grant = first pending slot scanning from last_grant+1 mod 4 upward; latch its address into sdram_addr; assert sdram_req next cycle; go REQ.
REQ-021 REQ: hold sdram_req=1 and sdram_addr stable; on sdram_ack go WAIT, sdram_req=0 the following cycle.
REQ-022 WAIT: on data_rdy write data_read to data[grant], tag[grant]=latched address, valid[grant]=1; last_grant=grant; go IDLE.
REQ-023 sdram_ack and data_rdy in same REQ cycle SHALL complete as in REQ-022.
REQ-024 data_rdy in IDLE and sdram_ack outside REQ SHALL be ignored.
REQ-025 Slot address change or cs drop during REQ/WAIT SHALL NOT abort; fill uses latched address, so changed slot misses and re-requests.
REQ-026 Timeout counter SHALL clear on leaving IDLE, increment each REQ/WAIT cycle; at count==TIMEOUT go IDLE, drop sdram_req, set timeout=1, no cache write, last_grant=grant.
REQ-027 downloading or loop_rst high SHALL clear all valid bits each cycle and force FSM to IDLE from any state with sdram_req=0 next cycle, no cache write.
REQ-028 Minimum miss latency SHALL be: cs at cycle 0, sdram_req at cycle 1, slot_ok the cycle after data_rdy.
REQ-029 timeout SHALL clear only by reset.

Reset
REQ-030 On rst_n low: FSM=IDLE, sdram_req=0, sdram_addr=0, all valid=0, tags=0, data=0 (slot_dout=0, slot_ok=0), last_grant=3, timeout counter=0, timeout=0; asynchronous assert, synchronous-release-safe.

Verification
REQ-031 Slot0 cs, addr 0x000100, ack 2 cycles after req, data_rdy 4 cycles later with 0xDEADBEEF -> sdram_addr=0x000100, slot_dout[31:0]=0xDEADBEEF, slot_ok[0]=1; repeat same addr -> ok with no sdram_req.
REQ-032 All four slots cs with distinct misses from reset -> grant order 0,1,2,3; each slot_ok rises once, sdram_req count=4.
REQ-033 Slot2 changes addr 0x10->0x20 during WAIT -> fill tag=0x10, slot_ok[2]=0, second request with sdram_addr=0x20.
REQ-034 Controller never asserts data_rdy, TIMEOUT=16 -> sdram_req low by cycle 17 after leaving IDLE, timeout=1, slot_ok stays 0, next pending slot granted.
REQ-035 downloading pulsed during WAIT, then valid data_rdy -> FSM IDLE, sdram_req=0, all slot_ok=0, no cache write; re-request after downloading falls.

Source files
------------

// File: rtl/jtframe_rom_arb.sv
// Four-slot ROM read cache arbitrating misses onto one SDRAM port.
// Round-robin grant, one outstanding transaction, abort on timeout or download.
module jtframe_rom_arb #(
    parameter int TIMEOUT = 1023
) (
    input  logic         clk_rom,
    input  logic         rst_n,
    input  logic         downloading,
    input  logic         loop_rst,
    input  logic [3:0]   slot_cs,
    input  logic [87:0]  slot_addr,
    output logic [127:0] slot_dout,
    output logic [3:0]   slot_ok,
    output logic         sdram_req,
    input  logic         sdram_ack,
    output logic [21:0]  sdram_addr,
    input  logic [31:0]  data_read,
    input  logic         data_rdy,
    output logic         timeout
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_valid;
    logic [21:0] r_tag [4];
    logic [31:0] r_data [4];
    logic [1:0]  r_grant, r_last;
    logic [11:0] r_cnt;
    logic        r_req, r_to;
    logic [21:0] r_addr;

    logic [3:0]  w_ok, w_pend;
    logic [1:0]  w_sel, w_idx;
    logic        w_any, w_block, w_tmo;
    logic        w_start, w_fill, w_abort;
    logic [21:0] w_saddr;

    assign w_block    = downloading | loop_rst;
    assign w_tmo      = (r_cnt == 12'(TIMEOUT));
    assign w_pend     = slot_cs & ~w_ok;
    assign slot_ok    = w_ok;
    assign sdram_req  = r_req;
    assign sdram_addr = r_addr;
    assign timeout    = r_to;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_ok[i] = slot_cs[i] & r_valid[i]
                    & (r_tag[i] == slot_addr[22*i +: 22]);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_dout
        assign slot_dout[32*g +: 32] = r_data[g];
    end

    // Round-robin scan starting just after the last granted slot
    always_comb begin
        w_any = 1'b0;
        w_sel = r_last;
        w_idx = r_last;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_any && w_pend[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
        w_saddr = slot_addr[22*w_sel +: 22];
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_fill  = 1'b0;
        w_abort = 1'b0;
        if (w_block) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        w_start = 1'b1;
                        w_next  = REQ;
                    end
                end
                REQ: begin
                    if (w_tmo) begin
                        w_abort = 1'b1;
                        w_next  = IDLE;
                    end else if (sdram_ack && data_rdy) begin
                        w_fill = 1'b1;
                        w_next = IDLE;
                    end else if (sdram_ack) begin
                        w_next = WAIT;
                    end
                end
                WAIT: begin
                    if (w_tmo) begin
                        w_abort = 1'b1;
                        w_next  = IDLE;
                    end else if (data_rdy) begin
                        w_fill = 1'b1;
                        w_next = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_grant <= 2'd0;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_to    <= 1'b0;
            r_addr  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_req <= (w_next == REQ);
            if (w_start) begin
                r_grant <= w_sel;
                r_addr  <= w_saddr;
                r_cnt   <= '0;
            end else if (r_state != IDLE) begin
                r_cnt <= r_cnt + 12'd1;
            end
            if (w_abort) begin
                r_to   <= 1'b1;
                r_last <= r_grant;
            end
            if (w_fill) begin
                r_data[r_grant] <= data_read;
                r_tag[r_grant]  <= r_addr;
                r_last          <= r_grant;
            end
            if (w_block)     r_valid          <= '0;
            else if (w_fill) r_valid[r_grant] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Bench for jtframe_rom_arb: transaction-level cache/arbiter model,
// randomized slot traffic and SDRAM responder, plus directed literal checks.
module tb_jtframe_rom_arb;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         downloading, loop_rst;
    logic [3:0]   slot_cs;
    logic [87:0]  slot_addr;
    logic [127:0] slot_dout;
    logic [3:0]   slot_ok;
    logic         sdram_req, sdram_ack;
    logic [21:0]  sdram_addr;
    logic [31:0]  data_read;
    logic         data_rdy, timeout;

    always #5 clk = ~clk;

    jtframe_rom_arb #(.TIMEOUT(TO)) dut (
        .clk_rom(clk), .rst_n(rst_n),
        .downloading(downloading), .loop_rst(loop_rst),
        .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_dout(slot_dout), .slot_ok(slot_ok),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .sdram_addr(sdram_addr), .data_read(data_read),
        .data_rdy(data_rdy), .timeout(timeout)
    );

    // model: cache contents plus the one outstanding transaction
    bit          mv [4];
    logic [21:0] mt [4];
    logic [31:0] md [4];
    bit          mbusy, mreq, mto, mnr;
    logic [1:0]  mg, mlast;
    logic [21:0] ma;
    int          mel;
    int          nvec = 0, nerr = 0;
    logic [21:0] raddr [4];

    function automatic logic [3:0] mok();
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = slot_cs[i] && mv[i] && (mt[i] == slot_addr[22*i +: 22]);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mv[i] = 0; mt[i] = '0; md[i] = '0;
        end
        mbusy = 0; mreq = 0; mto = 0; mnr = 0;
        mg = 0; mlast = 2'd3; ma = '0; mel = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        downloading = 0; loop_rst = 0; slot_cs = 0; slot_addr = 0;
        sdram_ack = 0; data_rdy = 0; data_read = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ok", 128'(slot_ok), 128'(0));
        chk("rst_dout", slot_dout, 128'(0));
        chk("rst_req_addr_to", {sdram_req, sdram_addr, timeout}, 128'(0));
        rst_n = 1'b1;
    endtask

    task automatic fill();
        mv[mg] = 1; mt[mg] = ma; md[mg] = data_read;
        mlast = mg; mbusy = 0; mreq = 0;
    endtask

    // One clock: drive at negedge, compare, then advance the model at posedge
    task automatic cyc(input logic [3:0] cs, input logic [87:0] ad,
                       input logic dl, input logic lr, input logic ack,
                       input logic rdy, input logic [31:0] rd);
        logic [3:0] ok;
        logic [1:0] s;
        bit found;
        slot_cs = cs; slot_addr = ad; downloading = dl; loop_rst = lr;
        sdram_ack = ack; data_rdy = rdy; data_read = rd;
        #1;
        ok = mok();
        chk("slot_ok", 128'(slot_ok), 128'(ok));
        chk("slot_dout", slot_dout, {md[3], md[2], md[1], md[0]});
        chk("req_addr_to", {sdram_req, sdram_addr, timeout},
            {mreq, ma, mto});
        @(posedge clk);
        if (dl || lr) begin
            for (int i = 0; i < 4; i++) mv[i] = 0;
            mbusy = 0; mreq = 0;
        end else if (!mbusy) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                s = mlast + 2'(k);
                if (!found && cs[s] && !ok[s]) begin
                    found = 1; mbusy = 1; mreq = 1; mg = s; mel = 0;
                    ma = ad[22*s +: 22];
                    mnr = ($urandom % 8 == 0);
                end
            end
        end else if (mel == TO) begin
            mbusy = 0; mreq = 0; mto = 1; mlast = mg;
        end else begin
            mel++;
            if (mreq) begin
                if (ack) begin
                    mreq = 0;
                    if (rdy) fill();
                end
            end else if (rdy) begin
                fill();
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [87:0] a;
        logic [3:0]  cs;
        logic        dl, lr, ak, rd;
        rst_n = 1'b0;
        @(negedge clk);

        // single miss then hit
        do_reset();
        a = 88'h000100;
        cyc(4'b0001, a, 0, 0, 0, 0, 0);
        chk("lit_req", 128'(sdram_req), 128'(1));
        chk("lit_addr", 128'(sdram_addr), 128'(22'h000100));
        repeat (2) cyc(4'b0001, a, 0, 0, 0, 0, 0);
        cyc(4'b0001, a, 0, 0, 1, 0, 0);
        chk("lit_req_drop", 128'(sdram_req), 128'(0));
        repeat (3) cyc(4'b0001, a, 0, 0, 0, 0, 0);
        cyc(4'b0001, a, 0, 0, 0, 1, 32'hDEADBEEF);
        chk("lit_ok0", 128'(slot_ok), 128'(4'b0001));
        chk("lit_dout0", 128'(slot_dout[31:0]), 128'(32'hDEADBEEF));
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0001, a, 0, 0, 0, 0, 0);
            chk("lit_hit_noreq", 128'(sdram_req), 128'(0));
        end

        // timeout, then next pending slot granted
        do_reset();
        a = {22'h0, 22'h66, 22'h55, 22'h0};
        cyc(4'b0110, a, 0, 0, 0, 0, 0);
        chk("lit_to_addr1", 128'(sdram_addr), 128'(22'h55));
        repeat (16) cyc(4'b0110, a, 0, 0, 0, 0, 0);
        chk("lit_to_pre", 128'({sdram_req, timeout}), 128'(2'b10));
        cyc(4'b0110, a, 0, 0, 0, 0, 0);
        chk("lit_to_post", 128'({sdram_req, timeout}), 128'(2'b01));
        chk("lit_to_ok", 128'(slot_ok), 128'(0));
        cyc(4'b0110, a, 0, 0, 0, 0, 0);
        chk("lit_to_next", 128'({sdram_req, sdram_addr}),
            128'({1'b1, 22'h66}));

        // randomized traffic
        do_reset();
        for (int i = 0; i < 4; i++) raddr[i] = 22'(16 * i);
        cs = 4'b0;
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom % 8 == 0) cs[i] = ~cs[i];
                if ($urandom % 16 == 0)
                    raddr[i] = 22'(16 * i + $urandom % 4);
            end
            a = {raddr[3], raddr[2], raddr[1], raddr[0]};
            dl = ($urandom % 64 == 0);
            lr = ($urandom % 128 == 0);
            if (mreq) ak = !mnr && ($urandom % 3 == 0);
            else      ak = ($urandom % 8 == 0);
            if (mbusy && !mreq)   rd = !mnr && ($urandom % 3 == 0);
            else if (mreq && ak)  rd = ($urandom % 4 == 0);
            else                  rd = ($urandom % 8 == 0);
            cyc(cs, a, dl, lr, ak, rd, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
